ft_recovery_ctrl: RTL

//  Lockstep error-recovery sequencer for the dual-core FT wrapper. Compares both cores' regfile write ports each

---
 rtl/ft_recovery_ctrl_pkg.sv | 24 ++
 rtl/ft_recovery_ctrl_if.sv | 33 +++
 rtl/ft_recovery_ctrl_lockstep_cmp.sv | 14 +
 rtl/ft_recovery_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/ft_recovery_ctrl_pkg.sv
// Shared types and default constants for the lockstep recovery controller.
package ft_recovery_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_RECOVER  = 2'd2,
    ST_RESET    = 2'd3
  } ft_state_e;

  localparam logic [31:0] HALT_ADDR_DEF       = 32'h100;
  localparam int          HALT_TIMEOUT_DEF    = 64;
  localparam int          RECOVER_TIMEOUT_DEF = 1024;
  localparam int          RESET_CYCLES_DEF    = 4;
  localparam int          GUARD_CYCLES_DEF    = 16;
  localparam int          CNT_W_DEF           = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// Core-facing signal bundle of the recovery controller; master drives, slave is the controller.
interface ft_recovery_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             enable_i;
  logic             we_a_i;
  logic             we_b_i;
  logic [4:0]       addr_a_i;
  logic [4:0]       addr_b_i;
  logic [31:0]      data_a_i;
  logic [31:0]      data_b_i;
  logic [31:0]      pc_i;
  logic             force_error_i;
  logic             done_i;
  logic             recover_o;
  logic             recovering_o;
  logic             reset_o;
  logic             error_o;
  logic [CNT_W-1:0] error_count_o;
  logic [1:0]       state_o;

  modport master (
    output enable_i, we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i,
           pc_i, force_error_i, done_i,
    input  recover_o, recovering_o, reset_o, error_o, error_count_o, state_o
  );

  modport slave (
    input  enable_i, we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i,
           pc_i, force_error_i, done_i,
    output recover_o, recovering_o, reset_o, error_o, error_count_o, state_o
  );
endinterface

// File: rtl/ft_recovery_ctrl_lockstep_cmp.sv
// Combinational comparison of the two cores' regfile write ports.
module ft_lockstep_cmp (
  input  logic        we_a,
  input  logic        we_b,
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        mismatch
);
  // Address/data only matter when both cores actually write.
  assign mismatch = (we_a != we_b) |
                    (we_a & we_b & ((addr_a != addr_b) | (data_a != data_b)));
endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep error-recovery sequencer: halt to debug routine, wait for completion, escalate to reset.
module ft_recovery_ctrl
  import ft_recovery_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR       = HALT_ADDR_DEF,
  parameter int          HALT_TIMEOUT    = HALT_TIMEOUT_DEF,
  parameter int          RECOVER_TIMEOUT = RECOVER_TIMEOUT_DEF,
  parameter int          RESET_CYCLES    = RESET_CYCLES_DEF,
  parameter int          GUARD_CYCLES    = GUARD_CYCLES_DEF,
  parameter int          CNT_W           = CNT_W_DEF
) (
  input logic               clk_i,
  input logic               rst_ni,
  ft_recovery_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(max3(HALT_TIMEOUT, RECOVER_TIMEOUT, RESET_CYCLES) + 1);
  localparam int GRD_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [TMR_W-1:0] HALT_LAST = TMR_W'(HALT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] REC_LAST  = TMR_W'(RECOVER_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RESET_CYCLES - 1);

  ft_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [GRD_W-1:0] guard_q;
  logic [CNT_W-1:0] count_q;
  logic             error_q;
  logic             mismatch;
  logic             err;
  logic             accept;

  ft_lockstep_cmp u_cmp (
    .we_a    (bus.we_a_i),
    .we_b    (bus.we_b_i),
    .addr_a  (bus.addr_a_i),
    .addr_b  (bus.addr_b_i),
    .data_a  (bus.data_a_i),
    .data_b  (bus.data_b_i),
    .mismatch(mismatch)
  );

  assign err    = bus.enable_i & (mismatch | bus.force_error_i);
  assign accept = (state_q == ST_RUN) & err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Completion conditions are tested ahead of the timeout so they win a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (err) state_d = (guard_q != '0) ? ST_RESET : ST_HALT_REQ;
      ST_HALT_REQ: if (bus.pc_i == HALT_ADDR) state_d = ST_RECOVER;
                   else if (tmr_q == HALT_LAST) state_d = ST_RESET;
      ST_RECOVER:  if (bus.done_i) state_d = ST_RUN;
                   else if (tmr_q == REC_LAST) state_d = ST_RESET;
      ST_RESET:    if (tmr_q == RST_LAST) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    bus.recover_o     = (state_q == ST_HALT_REQ);
    bus.recovering_o  = (state_q == ST_RECOVER);
    bus.reset_o       = (state_q == ST_RESET);
    bus.state_o       = state_q;
    bus.error_o       = error_q;
    bus.error_count_o = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   tmr_q <= '0;
    else if (state_d != state_q)   tmr_q <= '0;
    else if (state_q != ST_RUN)    tmr_q <= tmr_q + TMR_W'(1);
  end

  // Guard opens only on a successful recovery and is wiped by a core reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      guard_q <= '0;
    else if (state_q == ST_RECOVER && state_d == ST_RUN)
      guard_q <= GRD_W'(GUARD_CYCLES);
    else if (state_q == ST_RESET)
      guard_q <= '0;
    else if (state_q == ST_RUN && guard_q != '0)
      guard_q <= guard_q - GRD_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      error_q <= accept;
      if (accept && count_q != '1) count_q <= count_q + CNT_W'(1);
    end
  end

endmodule
